sisc_ifetch: RTL and testbench

- Instruction-fetch stage directly upstream of the SISC datapath.
- Owns the program counter and runs a req/ack handshake to instruction memory, which may have variable latency.
- Registers the fetched word into ir and presents it to the datapath and control unit with a valid/ready handshake.
- Accepts branch redirects from control, discards in-flight fetches, and stops fetching after a HLT instruction.

---
 rtl/sisc_ifetch.sv | 147 ++++++++++++++
 tb/tb_sisc_ifetch.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_ifetch.sv
// Instruction-fetch stage for the SISC core. It owns the PC, runs a req/ack handshake to
// variable-latency instruction memory, and hands fetched words to the datapath via ir.
module sisc_ifetch #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HLT_OP   = 4'hF
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              halted,
  output logic [2:0]        fsm_state
);

  // Consumer side: ir is transferred on a cycle where ir_valid && ir_ready at the rising edge;
  // while ir_valid is high and ir_ready is low, ir/ir_pc/ir_valid stay unchanged.
  typedef enum logic [2:0] {
    START   = 3'd0,
    FETCH   = 3'd1,
    FULL    = 3'd2,
    DISCARD = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n;
  logic [ADDR_W-1:0]   tgt, tgt_n;
  logic                req_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [31:0]         ir_n;
  logic [ADDR_W-1:0]   ir_pc_n;
  logic                valid_n;
  logic                halted_n;

  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state     <= START;
      pc        <= RESET_PC;
      tgt       <= '0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      ir        <= '0;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      tgt       <= tgt_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      ir        <= ir_n;
      ir_pc     <= ir_pc_n;
      ir_valid  <= valid_n;
      halted    <= halted_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    tgt_n    = tgt;
    req_n    = imem_req;
    addr_n   = imem_addr;
    ir_n     = ir;
    ir_pc_n  = ir_pc;
    valid_n  = ir_valid;
    halted_n = halted;
    case (state)
      START: begin
        state_n = FETCH;
        req_n   = 1'b1;
        if (br_taken) begin
          pc_n   = br_target;
          addr_n = br_target;
        end else begin
          addr_n = pc;
        end
      end
      FETCH: begin
        if (br_taken) begin
          if (imem_ack) begin
            // Returned word belongs to the old path; start the new fetch right away.
            pc_n   = br_target;
            addr_n = br_target;
          end else begin
            tgt_n   = br_target;
            state_n = DISCARD;
          end
        end else if (imem_ack) begin
          ir_n    = imem_data;
          ir_pc_n = pc;
          pc_n    = pc + ADDR_W'(1);
          valid_n = 1'b1;
          req_n   = 1'b0;
          state_n = FULL;
        end
      end
      FULL: begin
        if (br_taken) begin
          valid_n = 1'b0;
          pc_n    = br_target;
          addr_n  = br_target;
          req_n   = 1'b1;
          state_n = FETCH;
        end else if (ir_ready) begin
          valid_n = 1'b0;
          if (ir[31:28] == HLT_OP) begin
            halted_n = 1'b1;
            state_n  = HALT;
          end else begin
            req_n   = 1'b1;
            addr_n  = pc;
            state_n = FETCH;
          end
        end
      end
      DISCARD: begin
        // The outstanding transaction must finish before the redirect can be issued.
        if (imem_ack) begin
          pc_n    = br_taken ? br_target : tgt;
          addr_n  = br_taken ? br_target : tgt;
          state_n = FETCH;
        end else if (br_taken) begin
          tgt_n = br_target;
        end
      end
      HALT: begin
      end
      default: begin
        state_n = START;
      end
    endcase
  end

endmodule

// File: tb/tb_sisc_ifetch.sv
// Bench for sisc_ifetch: directed scenarios plus a randomized run against a flag-level
// reference model, with a second instance covering the RESET_PC=0xFFFF wrap case.
module tb_sisc_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT signals
  logic        imem_req, imem_ack = 1'b0;
  logic [15:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid, halted;
  logic        ir_ready = 1'b0, br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic [2:0]  fsm_state;

  // second DUT (RESET_PC = 0xFFFF)
  logic        rst2 = 1'b1;
  logic        req2, ack2 = 1'b0, valid2, halted2;
  logic        ready2 = 1'b0;
  logic [15:0] addr2, ir_pc2;
  logic [31:0] data2 = '0, ir2;
  logic [2:0]  state2;

  int checks = 0;
  int failures = 0;

  sisc_ifetch #(.ADDR_W(16), .RESET_PC(16'h0000), .HLT_OP(4'hF)) dut (
    .clk(clk), .rst_f(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .br_taken(br_taken),
    .br_target(br_target), .halted(halted), .fsm_state(fsm_state)
  );

  sisc_ifetch #(.ADDR_W(16), .RESET_PC(16'hFFFF), .HLT_OP(4'hF)) dut2 (
    .clk(clk), .rst_f(rst2), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_data(data2), .ir(ir2), .ir_pc(ir_pc2),
    .ir_valid(valid2), .ir_ready(ready2), .br_taken(1'b0),
    .br_target(16'h0000), .halted(halted2), .fsm_state(state2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory models ----------------
  logic [31:0] mem [0:65535];
  int          fix_lat = 0;
  bit          spur_en = 1'b0;
  bit          mem_busy = 1'b0;
  int          mem_wait = 0;
  logic [15:0] mem_a = '0;
  logic [15:0] ack_q[$];

  initial forever begin
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (rst || !imem_req) begin
      mem_busy = 1'b0;
      if (!rst && spur_en && $urandom_range(0, 5) == 0) begin
        imem_ack  = 1'b1;
        imem_data = $urandom;
      end
    end else begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_a    = imem_addr;
        mem_wait = (fix_lat >= 0) ? fix_lat : $urandom_range(0, 3);
      end
      if (mem_wait == 0) begin
        imem_ack  = 1'b1;
        imem_data = mem[mem_a];
        mem_busy  = 1'b0;
        ack_q.push_back(mem_a);
      end else begin
        mem_wait--;
      end
    end
  end

  int          lat2 = 0;
  int          cnt2 = 0;
  logic [15:0] ack2_q[$];

  initial forever begin
    @(posedge clk);
    #1;
    if (rst2 || !req2) begin
      ack2 = 1'b0;
      cnt2 = 0;
    end else if (cnt2 >= lat2) begin
      ack2  = 1'b1;
      data2 = mem[addr2];
      ack2_q.push_back(addr2);
      cnt2  = 0;
    end else begin
      ack2 = 1'b0;
      cnt2++;
    end
  end

  // ---------------- reference model (transaction flags, not states) ----------------
  logic        e_req = 1'b0, e_valid = 1'b0, e_halted = 1'b0;
  logic [15:0] e_addr = '0, e_ir_pc = '0;
  logic [31:0] e_ir = '0;
  bit          m_started = 1'b0, m_halt = 1'b0, m_drop = 1'b0;
  logic [15:0] m_pc = '0, m_tgt = '0;

  task automatic model_step();
    if (rst) begin
      e_req = 1'b0; e_addr = 16'h0000; e_ir = '0; e_ir_pc = '0; e_valid = 1'b0; e_halted = 1'b0;
      m_started = 1'b0; m_halt = 1'b0; m_drop = 1'b0; m_pc = 16'h0000; m_tgt = '0;
    end else if (m_halt) begin
      // nothing moves until reset
    end else if (!m_started) begin
      m_started = 1'b1;
      if (br_taken) m_pc = br_target;
      e_req  = 1'b1;
      e_addr = m_pc;
    end else if (e_valid) begin
      if (br_taken) begin
        e_valid = 1'b0; m_pc = br_target; e_addr = br_target; e_req = 1'b1;
      end else if (ir_ready) begin
        e_valid = 1'b0;
        if (e_ir[31:28] == 4'hF) begin
          m_halt = 1'b1; e_halted = 1'b1;
        end else begin
          e_req = 1'b1; e_addr = m_pc;
        end
      end
    end else if (imem_ack) begin
      if (m_drop || br_taken) begin
        m_pc   = br_taken ? br_target : m_tgt;
        e_addr = m_pc;
        m_drop = 1'b0;
      end else begin
        e_ir = imem_data; e_ir_pc = m_pc; m_pc = m_pc + 16'd1; e_valid = 1'b1; e_req = 1'b0;
      end
    end else if (br_taken) begin
      m_drop = 1'b1;
      m_tgt  = br_target;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("req", imem_req, e_req);
    chk("addr", imem_addr, e_addr);
    chk("ir", ir, e_ir);
    chk("ir_pc", ir_pc, e_ir_pc);
    chk("ir_valid", ir_valid, e_valid);
    chk("halted", halted, e_halted);
  end

  // ---------------- driver helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    br_taken = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_halted", halted, 1'b0);
    #2 rst = 1'b0;
    ack_q.delete();
  endtask

  task automatic wait_valid(input string nm, input int maxc);
    int n = 0;
    while (!ir_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, ir_valid, 1'b1);
  endtask

  task automatic wait_next_valid(input string nm, input int maxc);
    int n = 0;
    while (ir_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    wait_valid(nm, maxc);
  endtask

  task automatic next_ack(output logic [15:0] v);
    if (ack_q.size() > 0) v = ack_q.pop_front();
    else v = 16'hDEAD;
  endtask

  task automatic next_ack2(output logic [15:0] v);
    if (ack2_q.size() > 0) v = ack2_q.pop_front();
    else v = 16'hDEAD;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] w;
    logic [15:0] a;
    logic [31:0] saved2;
    int          cnt;
    bit          bad;

    for (int i = 0; i < 65536; i++) begin
      w = $urandom;
      if (w[31:28] == 4'hF) w[31:28] = 4'h7;
      if (i[7:0] == 8'hA5) w[31:28] = 4'hF;
      mem[i] = w;
    end
    mem[0]        = 32'h1000_0000;
    mem[1]        = 32'h2000_0000;
    mem[2]        = 32'h3000_0002;
    mem[5]        = 32'h5555_5555;
    mem[16'h0040] = 32'h4040_4040;
    mem[16'h0100] = 32'h0100_0100;
    mem[16'hFFFF] = 32'hABCD_0001;

    // 1: zero wait states, consumer always ready
    fix_lat = 0; ir_ready = 1'b1;
    do_reset();
    wait_valid("t1_v0", 20);
    chk("t1_ir0", ir, 32'h1000_0000);
    chk("t1_pc0", ir_pc, 16'h0000);
    wait_next_valid("t1_v1", 20);
    chk("t1_ir1", ir, 32'h2000_0000);
    chk("t1_pc1", ir_pc, 16'h0001);
    wait_next_valid("t1_v2", 20);
    chk("t1_pc2", ir_pc, 16'h0002);
    next_ack(a); chk("t1_a0", a, 16'h0000);
    next_ack(a); chk("t1_a1", a, 16'h0001);
    next_ack(a); chk("t1_a2", a, 16'h0002);

    // 2: three wait states, consumer stalls for five cycles
    fix_lat = 3; ir_ready = 1'b0;
    do_reset();
    cnt = 0; bad = 1'b0;
    for (int n = 0; n < 20 && !ir_valid; n++) begin
      @(negedge clk);
      if (imem_req) begin
        cnt++;
        if (imem_addr !== 16'h0000) bad = 1'b1;
      end
    end
    chk("t2_req_cycles", cnt, 4);
    chk("t2_addr_stable", bad, 1'b0);
    for (int n = 0; n < 5; n++) begin
      chk("t2_hold_ir", ir, 32'h1000_0000);
      chk("t2_hold_req", imem_req, 1'b0);
      @(negedge clk);
    end
    ir_ready = 1'b1;
    @(negedge clk);
    chk("t2_rel_req", imem_req, 1'b1);
    chk("t2_rel_addr", imem_addr, 16'h0001);
    ir_ready = 1'b0;

    // 3: redirect while a fetch to 5 is outstanding
    fix_lat = 0;
    do_reset();
    wait_valid("t3_v0", 20);
    fix_lat = 2;
    br_taken = 1'b1; br_target = 16'h0005;
    @(negedge clk);
    br_target = 16'h0040;
    @(negedge clk);
    br_taken = 1'b0;
    chk("t3_hold_addr", imem_addr, 16'h0005);
    @(negedge clk);
    chk("t3_hold_addr2", imem_addr, 16'h0005);
    chk("t3_no_valid", ir_valid, 1'b0);
    wait_valid("t3_v1", 30);
    chk("t3_ir", ir, 32'h4040_4040);
    chk("t3_pc", ir_pc, 16'h0040);
    next_ack(a); chk("t3_a0", a, 16'h0000);
    next_ack(a); chk("t3_a1", a, 16'h0005);
    next_ack(a); chk("t3_a2", a, 16'h0040);

    // 4: redirect in the same cycle as the ack
    fix_lat = 0;
    do_reset();
    @(negedge clk);
    br_taken = 1'b1; br_target = 16'h0100;
    @(negedge clk);
    br_taken = 1'b0;
    chk("t4_valid", ir_valid, 1'b0);
    chk("t4_req", imem_req, 1'b1);
    chk("t4_addr", imem_addr, 16'h0100);
    wait_valid("t4_v", 20);
    chk("t4_ir", ir, 32'h0100_0100);
    chk("t4_pc", ir_pc, 16'h0100);

    // 5: HLT at address 2
    saved2 = mem[2];
    mem[2] = 32'hF000_0000;
    fix_lat = -1; ir_ready = 1'b1;
    do_reset();
    for (int n = 0; n < 60 && !halted; n++) @(negedge clk);
    chk("t5_halted", halted, 1'b1);
    chk("t5_ir", ir, 32'hF000_0000);
    chk("t5_pc", ir_pc, 16'h0002);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      br_taken  = ($urandom_range(0, 1) == 1);
      br_target = $urandom;
      ir_ready  = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (imem_req) cnt++;
    end
    br_taken = 1'b0;
    chk("t5_no_req", cnt, 0);
    chk("t5_still_halted", halted, 1'b1);
    mem[2] = saved2;
    ir_ready = 1'b1; fix_lat = 0;
    do_reset();
    wait_valid("t5_restart", 20);
    chk("t5_restart_pc", ir_pc, 16'h0000);
    ir_ready = 1'b0;

    // 6: RESET_PC = 0xFFFF wraps, then async reset mid-fetch
    lat2 = 0; ready2 = 1'b1;
    @(negedge clk);
    #2 rst2 = 1'b0;
    for (int n = 0; n < 20 && !valid2; n++) @(negedge clk);
    chk("t6_v0", valid2, 1'b1);
    chk("t6_pc0", ir_pc2, 16'hFFFF);
    chk("t6_ir0", ir2, 32'hABCD_0001);
    @(negedge clk);
    for (int n = 0; n < 20 && !valid2; n++) @(negedge clk);
    chk("t6_v1", valid2, 1'b1);
    chk("t6_pc1", ir_pc2, 16'h0000);
    chk("t6_ir1", ir2, 32'h1000_0000);
    next_ack2(a); chk("t6_a0", a, 16'hFFFF);
    next_ack2(a); chk("t6_a1", a, 16'h0000);
    lat2 = 6;
    for (int n = 0; n < 20 && !req2; n++) @(negedge clk);
    chk("t6_in_fetch", req2, 1'b1);
    #2 rst2 = 1'b1;
    #1;
    chk("t6_async_req", req2, 1'b0);
    chk("t6_async_valid", valid2, 1'b0);
    chk("t6_async_addr", addr2, 16'hFFFF);
    chk("t6_async_ir", ir2, 32'h0);

    // 7: randomized run with spurious acks, redirects, HLTs and async resets
    fix_lat = -1; spur_en = 1'b1;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ir_ready  = ($urandom_range(0, 2) != 0);
      br_taken  = ($urandom_range(0, 9) == 0);
      br_target = ($urandom_range(0, 3) == 0) ? 16'h00A3 : 16'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    spur_en = 1'b0;
    br_taken = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
